// File: rtl/mul_sequencer_pkg.sv
// mul_pkg: definitions shared by the multiply sequencer slice.
//   XLEN      - datapath width of the shared ALU
//   state_t   - sequencer states (IDLE, RUN, DONE)
//   ALU_*     - ALU function select codes
package mul_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: request/response bundle between the hazard unit / EX
// stage (master) and the multiply sequencer (slave).
//   start, flush          - request and abort (master -> slave)
//   operand_a, operand_b  - multiplicand / multiplier, sampled with start
//   busy, done, result    - status and low-word product (slave -> master)
import mul_pkg::*;

interface mul_sequencer_if #(
    parameter int unsigned WIDTH = XLEN
);
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, flush, operand_a, operand_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, operand_a, operand_b,
        output busy, done, result
    );
endinterface

// File: rtl/mul_sequencer_alu.sv
// alu: shared combinational ALU.
//   input_a, input_b - operands
//   alu_function     - operation select (ALU_* codes)
//   alu_output       - result
//   zero             - high when alu_output is all zeros
import mul_pkg::*;

module alu #(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [2:0]       alu_function,
    output logic [WIDTH-1:0] alu_output,
    output logic             zero
);

    always_comb begin
        alu_output = '0;
        case (alu_function)
            ALU_ADD: alu_output = input_a + input_b;
            ALU_SUB: alu_output = input_a - input_b;
            ALU_AND: alu_output = input_a & input_b;
            ALU_OR:  alu_output = input_a | input_b;
            ALU_SLT: alu_output[0] = ($signed(input_a) < $signed(input_b));
            ALU_XOR: alu_output = input_a ^ input_b;
            default: alu_output = '0;
        endcase
    end

    assign zero = (alu_output == '0);

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle RV32M MUL (low word) built on the shared ALU
// by shift-and-add. Terminates early once no multiplier bits remain.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave side of mul_sequencer_if (start/flush/operands in,
//          busy/done/result out; all outputs registered)
import mul_pkg::*;

module mul_sequencer #(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    mul_sequencer_if.slave  bus
);

    localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [WIDTH-1:0] alu_sum;
    logic             alu_zero;
    logic [WIDTH-1:0] acc_step;

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .input_a      (acc_q),
        .input_b      (mcand_q),
        .alu_function (ALU_ADD),
        .alu_output   (alu_sum),
        .zero         (alu_zero)
    );

    // The zero flag plays no part in multiplication; keep it tied to a
    // consistency check so a broken ALU is visible in simulation.
    always_comb begin
        assert (alu_zero == (alu_sum == '0));
    end

    // Accumulator value for this RUN cycle, including the conditional add.
    assign acc_step = mplier_q[0] ? alu_sum : acc_q;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    mcand_d  = bus.operand_a;
                    mplier_d = bus.operand_b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                // Stop as soon as the remaining multiplier is empty; the
                // count limit only matters when bit WIDTH-1 is set.
                if (((mplier_q >> 1) == '0) || (count_q == CNT_LAST)) begin
                    state_d  = S_DONE;
                    result_d = acc_step;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides anything computed above, including a start.
        if (bus.flush) begin
            state_d  = S_IDLE;
            mcand_d  = mcand_q;
            mplier_d = mplier_q;
            acc_d    = acc_q;
            count_d  = count_q;
            result_d = result_q;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed bench for mul_sequencer. Expected products are
// queued when a multiply is issued and popped when done is observed.
module tb_mul_sequencer;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mul_sequencer_if #(.WIDTH(W)) bus ();

    mul_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_n(input logic [W-1:0] b);
        int n = 1;
        for (int i = 0; i < int'(W); i++)
            if (b[i]) n = i + 1;
        return n;
    endfunction

    // Waits (bounded) for done, counting busy cycles seen on the way.
    task automatic await_done(input string tag, input int budget, output int nbusy);
        nbusy = 0;
        for (int i = 0; i < budget && bus.done !== 1'b1; i++) begin
            if (bus.busy === 1'b1) nbusy++;
            tick();
        end
        check({tag, " done_seen"}, W'(bus.done), W'(1));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int nb;
        logic [W-1:0] exp;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        sb_q.push_back(a * b);
        tick();
        bus.start = 1'b0;
        check({tag, " busy_after_start"}, W'(bus.busy), W'(1));
        await_done(tag, W + 8, nb);
        check({tag, " busy_cycles"}, W'(nb), W'(exp_n(b)));
        exp = sb_q.pop_front();
        check({tag, " result"}, bus.result, exp);
        tick();
        check({tag, " done_pulse_len"}, W'(bus.done), W'(0));
        check({tag, " result_hold"}, bus.result, exp);
    endtask

    initial begin
        int nb;
        int seen;
        logic [W-1:0] exp;

        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;

        // Reset and idle
        tick();
        tick();
        check("rst busy", W'(bus.busy), W'(0));
        check("rst done", W'(bus.done), W'(0));
        check("rst result", bus.result, W'(0));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle busy", W'(bus.busy), W'(0));
            check("idle done", W'(bus.done), W'(0));
            check("idle result", bus.result, W'(0));
        end

        run_op("7x6", 32'd7, 32'd6);

        // Flush during the second RUN cycle
        bus.operand_a = 32'd9;
        bus.operand_b = 32'hFF;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush busy", W'(bus.busy), W'(0));
        check("flush done", W'(bus.done), W'(0));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
            tick();
        end
        check("flush no_activity", W'(seen), W'(0));
        check("flush result_kept", bus.result, 32'd42);

        // Flush and start together: nothing accepted
        bus.operand_a = 32'd1;
        bus.operand_b = 32'd1;
        bus.start     = 1'b1;
        bus.flush     = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start busy", W'(bus.busy), W'(0));
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
            tick();
        end
        check("flush_start no_activity", W'(seen), W'(0));
        check("flush_start result_kept", bus.result, 32'd42);

        run_op("neg1xmsb", 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("5x0", 32'd5, 32'd0);

        // Back-to-back with start held through the done cycle
        bus.operand_a = 32'd3;
        bus.operand_b = 32'd4;
        bus.start     = 1'b1;
        sb_q.push_back(32'd3 * 32'd4);
        tick();
        await_done("b2b first", W + 8, nb);
        check("b2b first busy_cycles", W'(nb), W'(3));
        exp = sb_q.pop_front();
        check("b2b first result", bus.result, exp);
        bus.operand_a = 32'h0001_0000;
        bus.operand_b = 32'h0001_0000;
        sb_q.push_back(32'h0001_0000 * 32'h0001_0000);
        tick();
        bus.start = 1'b0;
        check("b2b rerun busy", W'(bus.busy), W'(1));
        check("b2b rerun done", W'(bus.done), W'(0));
        check("b2b prev_result_kept", bus.result, 32'd12);
        await_done("b2b second", W + 8, nb);
        check("b2b second busy_cycles", W'(nb), W'(17));
        exp = sb_q.pop_front();
        check("b2b second result", bus.result, exp);
        tick();

        // Reset in the middle of a long RUN
        bus.operand_a = 32'hFFFF_FFFF;
        bus.operand_b = 32'h8000_0000;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst busy", W'(bus.busy), W'(0));
        check("midrst done", W'(bus.done), W'(0));
        check("midrst result", bus.result, W'(0));
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) seen++;
            tick();
        end
        check("midrst no_stray_done", W'(seen), W'(0));

        run_op("0x12345678x3", 32'h1234_5678, 32'd3);

        check("scoreboard drained", W'(sb_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
